// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg: op encoding, FSM states and reduction identity values
// shared by logic_unit_pipe and chunk_reducer.
package logic_unit_pkg;

    typedef enum logic [2:0] {
        OP_AND     = 3'd0,
        OP_OR      = 3'd1,
        OP_XOR     = 3'd2,
        OP_NAND    = 3'd3,
        OP_NOT     = 3'd4,
        OP_RED_AND = 3'd5,
        OP_RED_OR  = 3'd6,
        OP_RED_XOR = 3'd7
    } op_e;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_REDUCE = 1'b1
    } state_e;

    // Starting accumulator value so that folding every bit yields the reduction
    function automatic logic red_identity(op_e op);
        return (op == OP_RED_AND);
    endfunction

    function automatic logic is_reduction(op_e op);
        return (op == OP_RED_AND) || (op == OP_RED_OR) || (op == OP_RED_XOR);
    endfunction

endpackage

// File: rtl/logic_unit_pipe_chunk_reducer.sv
// chunk_reducer: folds CHUNK bits into a 1-bit accumulator for one
// reduction op. Purely combinational.
module chunk_reducer
    import logic_unit_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  op_e              op_i,
    input  logic             acc_i,
    input  logic [CHUNK-1:0] chunk_i,
    output logic             acc_o
);

    // Combine incoming accumulator with the reduction of this chunk
    always_comb begin
        acc_o = acc_i;
        case (op_i)
            OP_RED_AND: acc_o = acc_i & (&chunk_i);
            OP_RED_OR:  acc_o = acc_i | (|chunk_i);
            OP_RED_XOR: acc_o = acc_i ^ (^chunk_i);
            default:    acc_o = acc_i;
        endcase
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: bitwise ops in one cycle, reductions folded CHUNK bits
// per cycle, with a one-entry output register and valid/ready handshakes.
// Optional macro LOGIC_UNIT_PARITY_EN adds a registered parity output.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
`ifdef LOGIC_UNIT_PARITY_EN
    ,
    output logic             parity
`endif
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;

    op_e              op_in;
    logic             accept;
    logic [WIDTH-1:0] bit_res;

    op_e              fold_op;
    logic             fold_acc_in;
    logic             fold_acc_out;
    logic [CHUNK-1:0] fold_chunk;

    assign op_in     = op_e'(op);
    assign in_ready  = (state_q == S_IDLE) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign busy      = (state_q == S_REDUCE);

    // Single-cycle bitwise result for the incoming operands
    always_comb begin
        bit_res = '0;
        case (op_in)
            OP_AND:  bit_res = a & b;
            OP_OR:   bit_res = a | b;
            OP_XOR:  bit_res = a ^ b;
            OP_NAND: bit_res = ~(a & b);
            OP_NOT:  bit_res = ~a;
            default: bit_res = '0;
        endcase
    end

    // Reducer is shared: in IDLE it sees the raw input (used when one chunk
    // covers the whole word), in REDUCE it sees the latched operand.
    always_comb begin
        if (state_q == S_IDLE) begin
            fold_op     = op_in;
            fold_acc_in = red_identity(op_in);
            fold_chunk  = a[CHUNK-1:0];
        end else begin
            fold_op     = op_q;
            fold_acc_in = acc_q;
            fold_chunk  = a_q[CHUNK-1:0];
        end
    end

    chunk_reducer #(.CHUNK(CHUNK)) u_reducer (
        .op_i    (fold_op),
        .acc_i   (fold_acc_in),
        .chunk_i (fold_chunk),
        .acc_o   (fold_acc_out)
    );

    // Next-state, accumulator and output-register logic
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        out_valid_d = out_valid_q && !out_ready;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (!is_reduction(op_in)) begin
                        result_d    = bit_res;
                        out_valid_d = 1'b1;
                    end else if (NCHUNK == 1) begin
                        result_d    = WIDTH'(fold_acc_out);
                        out_valid_d = 1'b1;
                    end else begin
                        state_d = S_REDUCE;
                        op_d    = op_in;
                        a_d     = a;
                        acc_d   = red_identity(op_in);
                        cnt_d   = '0;
                    end
                end
            end
            S_REDUCE: begin
                acc_d = fold_acc_out;
                a_d   = a_q >> CHUNK;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(NCHUNK - 1)) begin
                    state_d     = S_IDLE;
                    result_d    = WIDTH'(fold_acc_out);
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset aborts any reduction in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= OP_AND;
            a_q         <= '0;
            acc_q       <= 1'b0;
            cnt_q       <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef LOGIC_UNIT_PARITY_EN
    logic parity_q;

    // Parity tracks whatever is loaded into the result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) parity_q <= 1'b0;
        else     parity_q <= ^result_d;
    end

    assign parity = parity_q;
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: directed tests for logic_unit_pipe (WIDTH=8, CHUNK=4).
// Inputs change and outputs are sampled on the falling edge.
module tb_logic_unit_pipe;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [2:0] op = 3'd0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       in_ready, out_valid, busy;
    logic [7:0] result;
`ifdef LOGIC_UNIT_PARITY_EN
    logic       parity;
`endif

    int errs = 0;
    int checks = 0;

    logic_unit_pipe #(.WIDTH(8), .CHUNK(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
`ifdef LOGIC_UNIT_PARITY_EN
        ,
        .parity    (parity)
`endif
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_ov: got %b exp 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b exp 0", busy); end
        checks++; if (result !== 8'h00) begin errs++; $display("FAIL reset_result: got %h exp 00", result); end
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
    endtask

    task automatic test_bitwise();
        logic [2:0] ops [5] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4};
        logic [7:0] av  [5] = '{8'hF0, 8'hF0, 8'hA5, 8'hA5, 8'h0E};
        logic [7:0] bv  [5] = '{8'h3C, 8'h3C, 8'h0F, 8'hFF, 8'h77};
        logic [7:0] ev  [5] = '{8'h30, 8'hCF, 8'hAF, 8'h5A, 8'hF1};
        out_ready = 1'b1;
        for (int i = 0; i <= 5; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++; if (out_valid !== 1'b1) begin errs++; $display("FAIL bitwise_ov[%0d]: got %b exp 1", i-1, out_valid); end
                checks++; if (result !== ev[i-1]) begin errs++; $display("FAIL bitwise_res[%0d]: got %h exp %h", i-1, result, ev[i-1]); end
            end
            if (i < 5) begin
                in_valid = 1'b1; op = ops[i]; a = av[i]; b = bv[i];
                #1;
                checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL bitwise_in_ready[%0d]: got %b exp 1", i, in_ready); end
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL bitwise_drain: got %b exp 0", out_valid); end
    endtask

    task automatic do_reduce(input logic [2:0] o, input logic [7:0] av, input logic [7:0] ev);
        @(negedge clk);
        in_valid = 1'b1; op = o; a = av; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; a = 8'h00;
        for (int c = 0; c < 2; c++) begin
            checks++; if (busy !== 1'b1) begin errs++; $display("FAIL reduce_busy op%0d a=%h c%0d: got %b exp 1", o, av, c, busy); end
            checks++; if (in_ready !== 1'b0) begin errs++; $display("FAIL reduce_in_ready op%0d a=%h c%0d: got %b exp 0", o, av, c, in_ready); end
            checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reduce_ov_early op%0d a=%h c%0d: got %b exp 0", o, av, c, out_valid); end
            @(negedge clk);
        end
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL reduce_done_busy op%0d a=%h: got %b exp 0", o, av, busy); end
        checks++; if (out_valid !== 1'b1) begin errs++; $display("FAIL reduce_ov op%0d a=%h: got %b exp 1", o, av, out_valid); end
        checks++; if (result !== ev) begin errs++; $display("FAIL reduce_res op%0d a=%h: got %h exp %h", o, av, result, ev); end
    endtask

    task automatic test_reduce();
        do_reduce(3'd5, 8'hFF, 8'h01);
        do_reduce(3'd5, 8'hFE, 8'h00);
        do_reduce(3'd6, 8'h10, 8'h01);
        do_reduce(3'd6, 8'h00, 8'h00);
        do_reduce(3'd7, 8'h07, 8'h01);
        do_reduce(3'd7, 8'h81, 8'h00);
    endtask

    task automatic test_stall();
        @(negedge clk);
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; op = 3'd7; a = 8'h07;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errs++; $display("FAIL stall_first_ov: got %b exp 1", out_valid); end
        in_valid = 1'b1; op = 3'd2; a = 8'hAA; b = 8'h55;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (result !== 8'h01) begin errs++; $display("FAIL stall_res c%0d: got %h exp 01", c, result); end
            checks++; if (in_ready !== 1'b0) begin errs++; $display("FAIL stall_in_ready c%0d: got %b exp 0", c, in_ready); end
            checks++; if (out_valid !== 1'b1) begin errs++; $display("FAIL stall_ov c%0d: got %b exp 1", c, out_valid); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL stall_release_in_ready: got %b exp 1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errs++; $display("FAIL stall_replace_ov: got %b exp 1", out_valid); end
        checks++; if (result !== 8'hFF) begin errs++; $display("FAIL stall_replace_res: got %h exp FF", result); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL stall_drain_ov: got %b exp 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] av [4] = '{8'h01, 8'h10, 8'hC0, 8'h00};
        logic [7:0] bv [4] = '{8'h02, 8'h20, 8'h03, 8'h00};
        logic [7:0] ev [4] = '{8'h03, 8'h30, 8'hC3, 8'h00};
        out_ready = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++; if (out_valid !== 1'b1) begin errs++; $display("FAIL b2b_ov[%0d]: got %b exp 1", i-1, out_valid); end
                checks++; if (result !== ev[i-1]) begin errs++; $display("FAIL b2b_res[%0d]: got %h exp %h", i-1, result, ev[i-1]); end
            end
            if (i < 4) begin
                in_valid = 1'b1; op = 3'd1; a = av[i]; b = bv[i];
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL b2b_drain: got %b exp 0", out_valid); end
    endtask

    task automatic test_rst_abort();
        @(negedge clk);
        in_valid = 1'b1; op = 3'd6; a = 8'h10; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errs++; $display("FAIL abort_pre_busy: got %b exp 1", busy); end
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL abort_busy: got %b exp 0", busy); end
        checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL abort_ov: got %b exp 0", out_valid); end
        checks++; if (result !== 8'h00) begin errs++; $display("FAIL abort_res: got %h exp 00", result); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errs++; $display("FAIL abort_in_ready: got %b exp 1", in_ready); end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b0) begin errs++; $display("FAIL abort_no_result c%0d: got %b exp 0", c, out_valid); end
        end
    endtask

`ifdef LOGIC_UNIT_PARITY_EN
    task automatic test_parity();
        @(negedge clk);
        in_valid = 1'b1; op = 3'd4; a = 8'h0E; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; op = 3'd0; a = 8'hF0; b = 8'h3C;
        checks++; if (result !== 8'hF1) begin errs++; $display("FAIL parity_res: got %h exp F1", result); end
        checks++; if (parity !== 1'b1) begin errs++; $display("FAIL parity_not: got %b exp 1", parity); end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (parity !== 1'b0) begin errs++; $display("FAIL parity_and: got %b exp 0", parity); end
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_bitwise();
        test_reduce();
        test_stall();
        test_back_to_back();
        test_rst_abort();
`ifdef LOGIC_UNIT_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
